// File: rtl/looped_nand_pkg.sv
// Shared types and the looped-NAND transfer function used by the monitor and its reference model.
package looped_nand_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } mon_state_e;

    function automatic logic nand_next(input logic in_bit, input logic reg_bit);
        return ~(in_bit & reg_bit);
    endfunction

endpackage

// File: rtl/looped_nand_model.sv
// Reference copy of the looped-NAND: one state bit fed back through a NAND with the stimulus.
module looped_nand_model
    import looped_nand_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    input  logic resync,
    input  logic in_bit,
    input  logic obs_bit,
    output logic exp_bit
);

    logic model_r;

    assign exp_bit = nand_next(in_bit, model_r);

    // Model state: cleared at run start, advanced on every comparison.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_r <= 1'b0;
        end else if (load) begin
            model_r <= 1'b0;
        end else if (step) begin
            model_r <= resync ? obs_bit : exp_bit;
        end else begin
            model_r <= model_r;
        end
    end

endmodule

// File: rtl/looped_nand_monitor.sv
// Cycle-by-cycle checker for a looped-NAND DUT; counts mismatches and records the first one.
// Optional LOOPED_NAND_MON_RESYNC_EN: on a mismatch the model adopts the DUT output.
module looped_nand_monitor
    import looped_nand_pkg::*;
#(
    parameter int NUM_CHECKS = 12,
    parameter int CNT_W      = 8,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             input1,
    input  logic             output1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_vld
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHECKS - 1);

    mon_state_e       state_r, state_nxt_s;
    logic             load_s, step_s, cmp_s, exp_s, resync_s, last_s;
    logic             busy_r, done_r, pass_r, mismatch_r, first_vld_r;
    logic [CNT_W-1:0] idx_r, first_idx_r;
    logic [ERR_W-1:0] err_r;

    looped_nand_model u_model (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .step    (step_s),
        .resync  (resync_s),
        .in_bit  (input1),
        .obs_bit (output1),
        .exp_bit (exp_s)
    );

    assign last_s = (idx_r == LAST_IDX);

    // Compare written so an unknown on either side takes the mismatch branch.
    always_comb begin
        cmp_s = 1'b1;
        if ((output1 ^ exp_s) == 1'b0) begin
            cmp_s = 1'b0;
        end else begin
            cmp_s = 1'b1;
        end
    end

`ifdef LOOPED_NAND_MON_RESYNC_EN
    assign resync_s = cmp_s;
`else
    assign resync_s = 1'b0;
`endif

    // Next-state and control decode.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = CHECK;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CHECK: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CHECK;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register, counters, capture registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            mismatch_r  <= 1'b0;
            idx_r       <= {CNT_W{1'b0}};
            err_r       <= {ERR_W{1'b0}};
            first_idx_r <= {CNT_W{1'b0}};
            first_vld_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s == CHECK);
            done_r     <= (state_r == DONE);
            mismatch_r <= step_s & cmp_s;
            if (load_s) begin
                idx_r       <= {CNT_W{1'b0}};
                err_r       <= {ERR_W{1'b0}};
                first_idx_r <= {CNT_W{1'b0}};
                first_vld_r <= 1'b0;
                pass_r      <= 1'b0;
            end else if (step_s) begin
                idx_r <= idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cmp_s) begin
                    if (err_r != {ERR_W{1'b1}}) begin
                        err_r <= err_r + {{(ERR_W-1){1'b0}}, 1'b1};
                    end
                    if (!first_vld_r) begin
                        first_idx_r <= idx_r;
                        first_vld_r <= 1'b1;
                    end
                end
            end else if (state_r == DONE) begin
                pass_r <= (err_r == {ERR_W{1'b0}});
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign mismatch      = mismatch_r;
    assign err_count     = err_r;
    assign first_err_idx = first_idx_r;
    assign first_err_vld = first_vld_r;

endmodule

// File: tb/tb_looped_nand_monitor.sv
// Directed bench for looped_nand_monitor; expectations follow LOOPED_NAND_MON_RESYNC_EN.
module tb_looped_nand_monitor;

    logic       clk, rst, start, input1, output1;
    logic       busy, done, pass, mismatch, first_err_vld;
    logic [7:0] err_count, first_err_idx;
    logic       s_busy, s_done, s_pass, s_mismatch, s_first_err_vld;
    logic [1:0] s_err_count;
    logic [7:0] s_first_err_idx;

    int cmp_cnt = 0;
    int bad_cnt = 0;

    // Stimulus/response tables, bit k = check index k
    localparam logic [11:0] IN_VEC   = 12'hE3C;
    localparam logic [11:0] GOLD_OUT = 12'h5EB;
    localparam logic [11:0] FLT_OUT  = 12'h5D7;
    localparam logic [11:0] INV_OUT  = 12'hA14;
`ifdef LOOPED_NAND_MON_RESYNC_EN
    localparam logic [11:0] FLT_MASK = 12'h004;
    localparam int          FLT_ERR  = 1;
    localparam logic [11:0] INV_MASK = 12'h1C3;
    localparam int          INV_ERR  = 5;
    localparam int          RST_ERR  = 1;
`else
    localparam logic [11:0] FLT_MASK = 12'h03C;
    localparam int          FLT_ERR  = 4;
    localparam logic [11:0] INV_MASK = 12'hFFF;
    localparam int          INV_ERR  = 12;
    localparam int          RST_ERR  = 4;
`endif

    looped_nand_monitor dut (
        .clk(clk), .rst(rst), .start(start), .input1(input1), .output1(output1),
        .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
        .err_count(err_count), .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
    );

    looped_nand_monitor #(.NUM_CHECKS(12), .CNT_W(8), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .input1(input1), .output1(output1),
        .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mismatch),
        .err_count(s_err_count), .first_err_idx(s_first_err_idx), .first_err_vld(s_first_err_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One full run; optional stray start pulse at check index start_at.
    task automatic run(input string tag, input logic [11:0] ov, input int start_at,
                       input logic [11:0] exp_mask, input int exp_err, input int exp_fidx,
                       input logic exp_fvld, input logic exp_pass);
        logic [11:0] mask;
        int          e, done_edge, done_hi;
        mask = 12'h000; done_edge = -1; done_hi = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); e = 0;
        chk({tag, "_busy_start"}, busy, 1'b1);
        for (int k = 0; k < 12; k++) begin
            input1  = IN_VEC[k];
            output1 = ov[k];
            start   = (k == start_at);
            @(negedge clk); e++;
            mask[k] = mismatch;
            if (done) begin done_hi++; if (done_edge < 0) done_edge = e; end
        end
        start = 1'b0;
        chk({tag, "_busy_end"}, busy, 1'b0);
        for (int w = 0; w < 4; w++) begin
            @(negedge clk); e++;
            if (done) begin done_hi++; if (done_edge < 0) done_edge = e; end
        end
        chk({tag, "_mask"}, mask, exp_mask);
        chk({tag, "_done_edge"}, done_edge, 13);
        chk({tag, "_done_width"}, done_hi, 1);
        chk({tag, "_err"}, err_count, exp_err);
        chk({tag, "_fvld"}, first_err_vld, exp_fvld);
        if (exp_fvld) chk({tag, "_fidx"}, first_err_idx, exp_fidx);
        else          chk({tag, "_fidx"}, first_err_idx, 0);
        chk({tag, "_pass"}, pass, exp_pass);
    endtask

    initial begin
        int done_seen;
        rst = 1'b0; start = 1'b0; input1 = 1'b0; output1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_mm",   mismatch, 1'b0);
        chk("rst_err",  err_count, 0);
        chk("rst_fvld", first_err_vld, 1'b0);
        rst = 1'b1;

        run("golden", GOLD_OUT, -1, 12'h000, 0, 0, 1'b0, 1'b1);
        run("fault",  FLT_OUT,  -1, FLT_MASK, FLT_ERR, 2, 1'b1, 1'b0);
        run("inv",    INV_OUT,  -1, INV_MASK, INV_ERR, 0, 1'b1, 1'b0);
        chk("sat_err",  s_err_count, 2'd3);
        chk("sat_pass", s_pass, 1'b0);
        run("stray_start", FLT_OUT, 5, FLT_MASK, FLT_ERR, 2, 1'b1, 1'b0);
        run("restart", GOLD_OUT, -1, 12'h000, 0, 0, 1'b0, 1'b1);

        // Reset in the middle of a faulty run
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            input1 = IN_VEC[k]; output1 = FLT_OUT[k];
            @(negedge clk);
        end
        chk("midrst_err_before", err_count, RST_ERR);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_err",  err_count, 0);
        chk("midrst_fvld", first_err_vld, 1'b0);
        done_seen = 0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst = 1'b1;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("midrst_no_done", done_seen, 0);
        chk("midrst_idle", busy, 1'b0);
        run("after_rst", GOLD_OUT, -1, 12'h000, 0, 0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
